// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module fifo_sync_flags #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 5,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 2**AWIDTH-2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DWIDTH-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int              DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] L_AF  = AF_THRESH[AWIDTH:0];
    localparam logic [AWIDTH:0] L_AE  = AE_THRESH[AWIDTH:0];

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH:0]   r_wptr;
    logic [AWIDTH:0]   r_rptr;
    logic              r_ovf;
    logic              r_unf;

    logic [AWIDTH:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Flags come only from the registered pointers, never from this cycle's requests.
    assign w_count  = r_wptr - r_rptr;
    assign w_full   = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                      (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= L_AF);
    assign almost_empty = (w_count <= L_AE);
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wptr[AWIDTH-1:0]] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd_acc)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    // A new error event on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wr_en && w_full)
                r_ovf <= 1'b1;
            else if (clr_err)
                r_ovf <= 1'b0;
            if (rd_en && w_empty)
                r_unf <= 1'b1;
            else if (clr_err)
                r_unf <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_rptr[AWIDTH-1:0]];
        end else begin : g_std
            logic [DWIDTH-1:0] r_dout;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_dout <= '0;
                else if (w_rd_acc)
                    r_dout <= r_mem[r_rptr[AWIDTH-1:0]];
            end
            assign data_out = r_dout;
        end
    endgenerate
endmodule
